gate_vector_checker: RTL

//  Self-checking stimulus/response stage for the basic-logic-gate library.
//  It drives every N_IN-bit input vector, in ascending order, to a gate under test (GUT).
//  It holds each vector for HOLD_CYCLES clocks, then samples the GUT output once.

---
 rtl/gate_chk_pkg.sv | 32 +++
 rtl/gate_vector_checker_if.sv | 36 +++
 rtl/hold_timer.sv | 31 +++
 rtl/gate_vector_checker.sv | 107 ++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and sizing helpers for the gate vector checker.
// Sizes derive from the N_IN and HOLD_CYCLES parameters of the instantiating module.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int N_IN_DEFAULT = 2;
   localparam int NVEC_DEFAULT = 2 ** N_IN_DEFAULT;

   function automatic int nvec(input int n_in);
      return 1 << n_in;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // A one-cycle hold still needs a 1-bit counter.
   function automatic int hold_w(input int h);
      return (clog2(h) < 1) ? 1 : clog2(h);
   endfunction

endpackage

// File: rtl/gate_vector_checker_if.sv
// Control, status and GUT-facing signals of the gate vector checker.
// slave = the checker itself; master = whoever starts runs and hosts the GUT.
// Handshake: start is a level sampled on every rising edge while the checker is
// IDLE or DONE; it is ignored during RUN. vec_valid qualifies vec_out; dut_out is
// combinational from vec_out and is sampled once per vector with no sync stage.
interface gate_vector_checker_if #(
   parameter int N_IN  = 2,
   parameter int ERR_W = 8
) ();

   logic                   start;
   logic [(1<<N_IN)-1:0]   expected_tt;
   logic                   dut_out;
   logic [N_IN-1:0]        vec_out;
   logic                   vec_valid;
   logic                   busy;
   logic                   done;
   logic                   pass;
   logic [ERR_W-1:0]       err_count;
   logic                   first_err_valid;
   logic [N_IN-1:0]        first_err_vec;
   gate_chk_pkg::state_t   state_dbg;

   modport master (
      output start, expected_tt, dut_out,
      input  vec_out, vec_valid, busy, done, pass, err_count,
             first_err_valid, first_err_vec, state_dbg
   );

   modport slave (
      input  start, expected_tt, dut_out,
      output vec_out, vec_valid, busy, done, pass, err_count,
             first_err_valid, first_err_vec, state_dbg
   );

endinterface

// File: rtl/hold_timer.sv
// Free-running hold counter; tick_out marks the last cycle of each hold window.
// clr pins the count at zero so every run begins with a full window.
module hold_timer
   import gate_chk_pkg::*;
#(
   parameter int HOLD_CYCLES = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick_out
);

   localparam int           W    = hold_w(HOLD_CYCLES);
   localparam logic [W-1:0] LAST = W'(HOLD_CYCLES - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick_out = (count == LAST);

endmodule

// File: rtl/gate_vector_checker.sv
// Walks every input vector through a gate under test, holding each for HOLD_CYCLES
// clocks, and checks the sampled response against a truth table latched at start.
module gate_vector_checker
   import gate_chk_pkg::*;
#(
   parameter int N_IN        = 2,
   parameter int HOLD_CYCLES = 5,
   parameter int ERR_W       = 8
) (
   input logic                  clk,
   input logic                  rst,
   gate_vector_checker_if.slave bus
);

   localparam int               NVEC     = nvec(N_IN);
   localparam logic [N_IN-1:0]  LAST_VEC = N_IN'(NVEC - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   state_t            state;
   logic [NVEC-1:0]   tt_q;
   logic [N_IN-1:0]   vec_q;
   logic              vec_valid_q;
   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [ERR_W-1:0]  err_q;
   logic              fev_valid_q;
   logic [N_IN-1:0]   fev_q;
   logic              tick;
   logic              timer_clr;
   logic              mismatch;

   assign timer_clr = (state != RUN);
   assign mismatch  = (bus.dut_out != tt_q[vec_q]);

   hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (timer_clr),
      .tick_out (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tt_q        <= '0;
         vec_q       <= '0;
         vec_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= '0;
         fev_valid_q <= 1'b0;
         fev_q       <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state       <= RUN;
                  tt_q        <= bus.expected_tt;
                  vec_q       <= '0;
                  vec_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  err_q       <= '0;
                  fev_valid_q <= 1'b0;
                  fev_q       <= '0;
               end
            end
            RUN: begin
               if (tick) begin
                  if (mismatch) begin
                     if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
                     if (!fev_valid_q) begin
                        fev_valid_q <= 1'b1;
                        fev_q       <= vec_q;
                     end
                  end
                  if (vec_q != LAST_VEC) begin
                     vec_q <= vec_q + 1'b1;
                  end else begin
                     // vec_out keeps the last vector so the GUT input stays stable.
                     state       <= DONE;
                     done_q      <= 1'b1;
                     busy_q      <= 1'b0;
                     vec_valid_q <= 1'b0;
                     pass_q      <= (err_q == '0) && !mismatch;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.vec_out         = vec_q;
   assign bus.vec_valid       = vec_valid_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.pass            = pass_q;
   assign bus.err_count       = err_q;
   assign bus.first_err_valid = fev_valid_q;
   assign bus.first_err_vec   = fev_q;
   assign bus.state_dbg       = state;

endmodule
